ethpipe_regs: RTL and testbench
===============================

# ethpipe_regs

Parametrised BAR0 control/status register block for the ethpipe PCIe endpoint. It decodes 16-bit slave-bus accesses into a global 64-bit timestamp counter, shared DMA status and length registers, and CHANNELS per-port DMA start/current address pairs. It adds per-channel saturating receive-packet counters, and atomic snapshot reads of every multi-word counter. It sits between pcie_tlp's slave bus and the receiver/DMA engines, replacing the hand-written register case in the mid-level module.

## Interface
- CHANNELS, 2, number of Ethernet/DMA channels, legal range 1..8
- ID_CODE, 8'hE2, block identifier returned in word 0x00
- clk_125  in  1  PCIe user clock; all logic is on this edge
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- slv_ce_i  in  1  access strobe, already qualified by BAR0 hit; one cycle per access
- slv_we_i  in  1  1 = write, 0 = read
- slv_adr_i  in  11 (bits [11:1])  16-bit word address
- slv_dat_i  in  16  write data, host byte order (see Operation)
- slv_sel_i  in  2  byte enables; [1] gates slv_dat_i[15:8], [0] gates slv_dat_i[7:0]
- slv_dat_o  out  16  registered read data
- rx_pkt_inc  in  CHANNELS  one-cycle pulse per received frame, per channel
- dma_addr_cur  in  30*CHANNELS  current DMA write pointer [31:2], channel n at [30n+29:30n]
- global_counter  out  64  free-running timestamp
- dma_status  out  8  DMA control/status byte
- dma_length  out  22 (bits [23:2])  ring length in dwords
- dma_addr_start  out  30*CHANNELS  ring base [31:2] per channel, same packing as dma_addr_cur

## Operation
- Decode only when slv_adr_i[11:7] == 0; word index w = slv_adr_i[6:1]. Any other access: reads return 0, writes ignored.
- Byte order: a logical 16-bit value V is read as {V[7:0], V[15:8]}. On write, slv_dat_i[15:8] (sel[1]) updates V[7:0] and slv_dat_i[7:0] (sel[0]) updates V[15:8].
- Map (V given logically):
  - 0x00 RO: {ID_CODE, CHANNELS[7:0]}.
  - 0x02–0x05: global_counter words 0–3.
    - Read of 0x02 returns counter[15:0] and latches counter[63:16] into a shadow; reads of 0x03–0x05 return the shadow.
    - Any write to 0x02 clears the counter.
  - 0x08 RW: {8'h00, dma_status}.
  - 0x0A RW: {dma_length[15:2], 2'b00}.
  - 0x0B RW: {8'h00, dma_length[23:16]}.
  - 0x10+4n RW: {start_n[15:2], 2'b00}.
  - 0x11+4n RW: start_n[31:16].
  - 0x12+4n RO: {cur_n[15:2], 2'b00}, sampled at read.
  - 0x13+4n RO: cur_n[31:16] from a snapshot taken when 0x12+4n was read.
  - 0x30+2n: pkt_n[15:0]; a read latches pkt_n[31:16] into the channel shadow.
  - 0x31+2n: the shadowed pkt_n[31:16].
  - Any write to 0x30+2n or 0x31+2n clears pkt_n.
  - Writes to bits 1:0 of address registers are discarded.
  - Words for n >= CHANNELS and all unlisted words: read 0, write ignored.
- global_counter increments by 1 every cycle and wraps at 2^64.
- pkt_n increments on rx_pkt_inc[n] and saturates at 32'hFFFF_FFFF.
- Simultaneous clear write and rx_pkt_inc[n]: pkt_n becomes 1.
- Counter-clear write to 0x02: global_counter is 0 on the following cycle, then resumes counting.

## Timing
- Read latency 1: slv_dat_o is valid the cycle after slv_ce_i & ~slv_we_i and holds until the next read.
- Writes take effect on the slv_ce_i edge. New register values are visible on the outputs the next cycle.
- Shadow latch happens on the same edge as the low-word read. Shadows persist until the next low-word read.
- Reset values:
  - slv_dat_o = 0, global_counter = 0, dma_status = 0.
  - dma_length = 22'h4000 (64 KiB).
  - dma_addr_start for channel n = (32'h1000_0000 + n·32'h0010_0000) >> 2.
  - All pkt_n and shadows = 0.
- Reset asserted mid-access aborts it; all state returns to reset values immediately, independent of clk_125.
- No backpressure; one access per cycle is sustainable.

## Test plan
- After reset, read 0x00, 0x0A, 0x11 and 0x15 with CHANNELS = 2. Expect:
  - 0x00 → 16'h02E2
  - 0x0A → 16'h0000
  - 0x11 → 16'h0010
  - 0x15 → 16'h1010
- Write 0x10 with data 16'h3412, sel = 2'b11, then read back.
  - Expect dma_addr_start[29:0] low bits = 16'h1234 >> 2, i.e. bits [15:2] = 14'h048D.
  - Expect readback 16'h3412 with bits 1:0 of V cleared.
- Hold the counter near a 16-bit carry, read 0x02, wait 100 cycles, then read 0x03.
  - Expect 0x03 to return the upper word captured at the 0x02 read, not the live value.
  - Write 0x02 and confirm global_counter == 1 two cycles later.
- Pulse rx_pkt_inc[1] 5 times and read 0x32 → 16'h0500.
  - Write 0x33 in the same cycle as a pulse, then read 0x32 → 16'h0100.
- Preload pkt_0 to 32'hFFFF_FFFE, apply 3 pulses, read 0x30/0x31 → both 16'hFFFF (saturated).
- With CHANNELS = 1, write 0x14 and read 0x14 → 0, and dma_addr_start is unchanged.
  - Assert sys_rst_n low asynchronously between edges → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/ethpipe_regs.sv
// ethpipe BAR0 control/status register block.
// Timestamp, DMA setup, per-channel packet counters, atomic snapshots.
module ethpipe_regs #(
    parameter int         CHANNELS = 2,
    parameter logic [7:0] ID_CODE  = 8'hE2
) (
    input  logic                    clk_125,
    input  logic                    sys_rst_n,
    input  logic                    slv_ce_i,
    input  logic                    slv_we_i,
    input  logic [11:1]             slv_adr_i,
    input  logic [15:0]             slv_dat_i,
    input  logic [1:0]              slv_sel_i,
    output logic [15:0]             slv_dat_o,
    input  logic [CHANNELS-1:0]     rx_pkt_inc,
    input  logic [30*CHANNELS-1:0]  dma_addr_cur,
    output logic [63:0]             global_counter,
    output logic [7:0]              dma_status,
    output logic [23:2]             dma_length,
    output logic [30*CHANNELS-1:0]  dma_addr_start
);

    // Bus byte lanes are swapped: dat[15:8] carries V[7:0], dat[7:0] carries V[15:8].
    function automatic logic [15:0] merge16(
        input logic [15:0] cur,
        input logic [15:0] dat,
        input logic [1:0]  sel
    );
        merge16 = {sel[0] ? dat[7:0]   : cur[15:8],
                   sel[1] ? dat[15:8]  : cur[7:0]};
    endfunction

    // Same merge for a V[15:2] field; V[1:0] is hardwired zero.
    function automatic logic [13:0] merge14(
        input logic [13:0] cur,
        input logic [15:0] dat,
        input logic [1:0]  sel
    );
        merge14 = {sel[0] ? dat[7:0]   : cur[13:6],
                   sel[1] ? dat[15:10] : cur[5:0]};
    endfunction

    logic        dec;
    logic [5:0]  w;
    logic        wr;
    logic        rd;
    logic        rd_dec;
    logic [47:0] gc_sh;
    logic [15:0] rd_val;

    logic [29:0] st_a     [CHANNELS];
    logic [13:0] cur_lo_a [CHANNELS];
    logic [15:0] cur_sh_a [CHANNELS];
    logic [15:0] cnt_lo_a [CHANNELS];
    logic [15:0] cnt_sh_a [CHANNELS];

    assign dec    = (slv_adr_i[11:7] == 5'd0);
    assign w      = slv_adr_i[6:1];
    assign wr     = slv_ce_i & slv_we_i & dec;
    assign rd     = slv_ce_i & ~slv_we_i;
    assign rd_dec = rd & dec;

    // Free-running timestamp; a write to its low word restarts it from zero.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            global_counter <= 64'd0;
        end else if (wr && w == 6'h02) begin
            global_counter <= 64'd0;
        end else begin
            global_counter <= global_counter + 64'd1;
        end
    end

    // Upper timestamp words frozen when the low word is read.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gc_sh <= 48'd0;
        end else if (rd_dec && w == 6'h02) begin
            gc_sh <= global_counter[63:16];
        end
    end

    // Shared DMA status and ring length registers.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dma_status <= 8'h00;
            dma_length <= 22'h4000;
        end else if (wr) begin
            if (w == 6'h08 && slv_sel_i[1]) begin
                dma_status <= slv_dat_i[15:8];
            end
            if (w == 6'h0A) begin
                dma_length[15:2] <= merge14(dma_length[15:2],
                                            slv_dat_i, slv_sel_i);
            end
            if (w == 6'h0B && slv_sel_i[1]) begin
                dma_length[23:16] <= slv_dat_i[15:8];
            end
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        localparam logic [5:0]  AW   = 6'(16 + 4 * n);
        localparam logic [5:0]  PW   = 6'(48 + 2 * n);
        localparam logic [31:0] BASE = 32'h1000_0000 + 32'(n) * 32'h0010_0000;

        logic [29:0] start;
        logic [29:0] cur;
        logic [15:0] cur_sh;
        logic [31:0] cnt;
        logic [15:0] cnt_sh;

        assign cur = dma_addr_cur[30*n +: 30];

        // Ring base address, written as two halves.
        always_ff @(posedge clk_125 or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                start <= BASE[31:2];
            end else if (wr && w == AW) begin
                start[13:0] <= merge14(start[13:0], slv_dat_i, slv_sel_i);
            end else if (wr && w == AW + 6'd1) begin
                start[29:14] <= merge16(start[29:14], slv_dat_i, slv_sel_i);
            end
        end

        // Saturating frame counter; a clear coinciding with a frame yields 1.
        always_ff @(posedge clk_125 or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt <= 32'd0;
            end else if (wr && (w == PW || w == PW + 6'd1)) begin
                cnt <= {31'd0, rx_pkt_inc[n]};
            end else if (rx_pkt_inc[n] && cnt != 32'hFFFF_FFFF) begin
                cnt <= cnt + 32'd1;
            end
        end

        // High-half snapshots taken on the low-word read.
        always_ff @(posedge clk_125 or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cur_sh <= 16'd0;
                cnt_sh <= 16'd0;
            end else begin
                if (rd_dec && w == AW + 6'd2) begin
                    cur_sh <= cur[29:14];
                end
                if (rd_dec && w == PW) begin
                    cnt_sh <= cnt[31:16];
                end
            end
        end

        assign dma_addr_start[30*n +: 30] = start;
        assign st_a[n]     = start;
        assign cur_lo_a[n] = cur[13:0];
        assign cur_sh_a[n] = cur_sh;
        assign cnt_lo_a[n] = cnt[15:0];
        assign cnt_sh_a[n] = cnt_sh;
    end

    // Read mux producing the logical value V of the addressed word.
    always_comb begin
        rd_val = 16'h0000;
        case (w)
            6'h00:   rd_val = {ID_CODE, 8'(CHANNELS)};
            6'h02:   rd_val = global_counter[15:0];
            6'h03:   rd_val = gc_sh[15:0];
            6'h04:   rd_val = gc_sh[31:16];
            6'h05:   rd_val = gc_sh[47:32];
            6'h08:   rd_val = {8'h00, dma_status};
            6'h0A:   rd_val = {dma_length[15:2], 2'b00};
            6'h0B:   rd_val = {8'h00, dma_length[23:16]};
            default: rd_val = 16'h0000;
        endcase
        for (int n = 0; n < CHANNELS; n++) begin
            if (w == 6'(16 + 4 * n)) rd_val = {st_a[n][13:0], 2'b00};
            if (w == 6'(17 + 4 * n)) rd_val = st_a[n][29:14];
            if (w == 6'(18 + 4 * n)) rd_val = {cur_lo_a[n], 2'b00};
            if (w == 6'(19 + 4 * n)) rd_val = cur_sh_a[n];
            if (w == 6'(48 + 2 * n)) rd_val = cnt_lo_a[n];
            if (w == 6'(49 + 2 * n)) rd_val = cnt_sh_a[n];
        end
        if (!dec) rd_val = 16'h0000;
    end

    // Registered read data, byte-swapped to host order.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slv_dat_o <= 16'h0000;
        end else if (rd) begin
            slv_dat_o <= {rd_val[7:0], rd_val[15:8]};
        end
    end

endmodule

// File: tb/tb_ethpipe_regs.sv
// Directed self-checking bench for ethpipe_regs.
// Main instance has two channels, a second instance has one.
module tb_ethpipe_regs;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce    = 1'b0;
    logic        ce1   = 1'b0;
    logic        we    = 1'b0;
    logic [11:1] adr   = '0;
    logic [15:0] dat   = '0;
    logic [1:0]  sel   = '0;
    logic [1:0]  rx    = '0;
    logic [0:0]  rx1   = '0;
    logic [59:0] cur   = '0;
    logic [29:0] cur1  = '0;

    logic [15:0] dat_o;
    logic [15:0] dat_o1;
    logic [63:0] gc;
    logic [63:0] gc1;
    logic [7:0]  st;
    logic [7:0]  st1;
    logic [23:2] len;
    logic [23:2] len1;
    logic [59:0] start;
    logic [29:0] start1;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] rv;

    always #5 clk = ~clk;

    ethpipe_regs #(.CHANNELS(2), .ID_CODE(8'hE2)) dut (
        .clk_125        (clk),
        .sys_rst_n      (rst_n),
        .slv_ce_i       (ce),
        .slv_we_i       (we),
        .slv_adr_i      (adr),
        .slv_dat_i      (dat),
        .slv_sel_i      (sel),
        .slv_dat_o      (dat_o),
        .rx_pkt_inc     (rx),
        .dma_addr_cur   (cur),
        .global_counter (gc),
        .dma_status     (st),
        .dma_length     (len),
        .dma_addr_start (start)
    );

    ethpipe_regs #(.CHANNELS(1), .ID_CODE(8'hE2)) dut1 (
        .clk_125        (clk),
        .sys_rst_n      (rst_n),
        .slv_ce_i       (ce1),
        .slv_we_i       (we),
        .slv_adr_i      (adr),
        .slv_dat_i      (dat),
        .slv_sel_i      (sel),
        .slv_dat_o      (dat_o1),
        .rx_pkt_inc     (rx1),
        .dma_addr_cur   (cur1),
        .global_counter (gc1),
        .dma_status     (st1),
        .dma_length     (len1),
        .dma_addr_start (start1)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input bit d1, input logic [10:0] a,
                          input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        ce  = ~d1;
        ce1 = d1;
        we  = 1'b1;
        adr = a;
        dat = d;
        sel = s;
        @(posedge clk);
        #1;
        ce  = 1'b0;
        ce1 = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_rd(input bit d1, input logic [10:0] a,
                          output logic [15:0] q);
        @(negedge clk);
        ce  = ~d1;
        ce1 = d1;
        we  = 1'b0;
        adr = a;
        @(posedge clk);
        #1;
        ce  = 1'b0;
        ce1 = 1'b0;
        q   = d1 ? dat_o1 : dat_o;
    endtask

    task automatic pulse(input logic [1:0] m);
        @(negedge clk);
        rx = m;
        @(posedge clk);
        #1;
        rx = 2'b00;
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_dat_o", dat_o, 16'h0000);
        check("rst_gc", gc, 64'd0);
        check("rst_status", st, 8'h00);
        check("rst_length", len, 22'h4000);
        check("rst_start", start, {30'h0404_0000, 30'h0400_0000});
        check("rst_start_c1", start1, 30'h0400_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset-state readback
        bus_rd(1'b0, 11'h000, rv); check("rd_id", rv, 16'h02E2);
        bus_rd(1'b0, 11'h00A, rv); check("rd_len_lo", rv, 16'h0000);
        bus_rd(1'b0, 11'h00B, rv); check("rd_len_hi", rv, 16'h0100);
        bus_rd(1'b0, 11'h011, rv); check("rd_start0_hi", rv, 16'h0010);
        bus_rd(1'b0, 11'h015, rv); check("rd_start1_hi", rv, 16'h1010);

        // start address write with byte swap and low-bit discard
        bus_wr(1'b0, 11'h010, 16'h3412, 2'b11);
        check("start0_lo", start[13:0], 14'h048D);
        check("start1_untouched", start[59:30], 30'h0404_0000);
        bus_rd(1'b0, 11'h010, rv); check("rd_start0_lo", rv, 16'h3412);
        bus_wr(1'b0, 11'h010, 16'h0700, 2'b10);
        bus_rd(1'b0, 11'h010, rv); check("rd_start0_lo_b10", rv, 16'h0412);
        bus_wr(1'b0, 11'h011, 16'hAB00, 2'b10);
        check("start0_hi_sel", start[29:14], 16'h10AB);
        bus_rd(1'b0, 11'h011, rv); check("rd_start0_hi_sel", rv, 16'hAB10);

        // status and length
        bus_wr(1'b0, 11'h008, 16'h5A77, 2'b11);
        check("status_wr", st, 8'h5A);
        bus_rd(1'b0, 11'h008, rv); check("rd_status", rv, 16'h5A00);
        bus_wr(1'b0, 11'h008, 16'hFFFF, 2'b00);
        check("status_sel0", st, 8'h5A);
        bus_wr(1'b0, 11'h00A, 16'hFFFF, 2'b11);
        check("length_lo", len, 22'h7FFF);
        bus_rd(1'b0, 11'h00A, rv); check("rd_len_lo2", rv, 16'hFCFF);

        // undecoded accesses
        bus_wr(1'b0, 11'h408, 16'hFFFF, 2'b11);
        check("alias_wr_ignored", st, 8'h5A);
        bus_rd(1'b0, 11'h440, rv); check("alias_rd_zero", rv, 16'h0000);
        bus_rd(1'b0, 11'h006, rv); check("unmapped_rd", rv, 16'h0000);

        // DMA current pointer snapshot
        cur[29:0]  = 30'h37AB_6FBB;
        cur[59:30] = 30'h048D_159E;
        bus_rd(1'b0, 11'h012, rv); check("rd_cur0_lo", rv, 16'hECBE);
        cur[29:0] = 30'h0;
        bus_rd(1'b0, 11'h013, rv); check("rd_cur0_snap", rv, 16'hADDE);
        bus_rd(1'b0, 11'h016, rv); check("rd_cur1_lo", rv, 16'h7856);

        // timestamp clear and atomic read across a 16-bit carry
        bus_wr(1'b0, 11'h002, 16'h0000, 2'b11);
        check("gc_cleared", gc, 64'd0);
        @(posedge clk);
        #1;
        check("gc_resume", gc, 64'd1);
        repeat (65534) @(posedge clk);
        bus_rd(1'b0, 11'h002, rv); check("rd_gc_w0", rv, 16'hFFFF);
        repeat (100) @(posedge clk);
        bus_rd(1'b0, 11'h003, rv); check("rd_gc_w1_snap", rv, 16'h0000);
        bus_rd(1'b0, 11'h002, rv); check("rd_gc_w0_b", rv, 16'h6500);
        bus_rd(1'b0, 11'h003, rv); check("rd_gc_w1_b", rv, 16'h0100);
        bus_rd(1'b0, 11'h004, rv); check("rd_gc_w2", rv, 16'h0000);

        // packet counters
        repeat (5) pulse(2'b10);
        bus_rd(1'b0, 11'h032, rv); check("rd_pkt1", rv, 16'h0500);
        bus_rd(1'b0, 11'h033, rv); check("rd_pkt1_hi", rv, 16'h0000);
        bus_rd(1'b0, 11'h030, rv); check("rd_pkt0", rv, 16'h0000);
        @(negedge clk);
        ce  = 1'b1;
        we  = 1'b1;
        adr = 11'h033;
        dat = 16'h0000;
        sel = 2'b11;
        rx  = 2'b10;
        @(posedge clk);
        #1;
        ce = 1'b0;
        we = 1'b0;
        rx = 2'b00;
        bus_rd(1'b0, 11'h032, rv); check("rd_pkt1_clr_inc", rv, 16'h0100);
        bus_wr(1'b0, 11'h032, 16'h0000, 2'b11);
        bus_rd(1'b0, 11'h032, rv); check("rd_pkt1_clr", rv, 16'h0000);

        // saturation
        @(negedge clk);
        force dut.g_ch[0].cnt = 32'hFFFF_FFFE;
        #1;
        release dut.g_ch[0].cnt;
        repeat (3) pulse(2'b01);
        bus_rd(1'b0, 11'h030, rv); check("rd_pkt0_sat_lo", rv, 16'hFFFF);
        bus_rd(1'b0, 11'h031, rv); check("rd_pkt0_sat_hi", rv, 16'hFFFF);

        // single-channel instance
        bus_rd(1'b1, 11'h000, rv); check("c1_rd_id", rv, 16'h01E2);
        bus_wr(1'b1, 11'h014, 16'hFFFF, 2'b11);
        check("c1_start_kept", start1, 30'h0400_0000);
        bus_rd(1'b1, 11'h014, rv); check("c1_rd_ch1", rv, 16'h0000);
        bus_wr(1'b1, 11'h008, 16'hC300, 2'b11);
        check("c1_status", st1, 8'hC3);

        // asynchronous reset between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dat_o", dat_o, 16'h0000);
        check("arst_gc", gc, 64'd0);
        check("arst_status", st, 8'h00);
        check("arst_length", len, 22'h4000);
        check("arst_start", start, {30'h0404_0000, 30'h0400_0000});
        check("arst_c1_dat_o", dat_o1, 16'h0000);
        check("arst_c1_gc", gc1, 64'd0);
        check("arst_c1_status", st1, 8'h00);
        check("arst_c1_length", len1, 22'h4000);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(1'b0, 11'h030, rv); check("post_rst_pkt0", rv, 16'h0000);
        bus_rd(1'b0, 11'h031, rv); check("post_rst_pkt0_hi", rv, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
